seq_divider: RTL

- Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU, one quotient bit per cycle.
- Sits in the execute stage directly downstream of the ALU.
- The ALU raises start with latched operands, holds start until ready, then drops start.
- result is written to HI/LO as {remainder, quotient}.

---
 rtl/seq_divider.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU. It produces one
// quotient bit per clock and sits in the execute stage behind the ALU.
//
// Handshake: the ALU raises start with the operands valid and holds it until it
// sees ready. It then drops start, and the divider returns to IDLE. annul
// aborts any operation in flight.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   signed_div  1 = DIV (two's complement), 0 = DIVU; sampled with start in IDLE
//   opdata1     dividend; sampled in IDLE only
//   opdata2     divisor; sampled in IDLE only
//   start       request level, held until ready
//   annul       abort (exception flush); overrides start
//   result      {remainder, quotient}; valid while ready = 1
//   ready       result valid
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               start,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BYZERO = 2'd1,
    ST_ON     = 2'd2,
    ST_END    = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]        cnt;
  logic                 dvd_neg;
  logic                 dvs_neg;
  logic [WIDTH-1:0]     dvs_mag;
  // Working register: [2W-1:W] is the partial remainder and [W-1:0] holds the
  // dividend bits not yet consumed, with quotient bits filling in from the LSB.
  // The partial remainder is always below the divisor, so W bits are enough.
  logic [2*WIDTH-1:0]   work;
  logic [2*WIDTH:0]     work_shl;
  logic signed [WIDTH:0] trial;
  logic [2*WIDTH-1:0]   work_step;
  logic                 go;
  logic                 last_iter;

  // Two's-complement negation when neg is set, else pass-through.
  function automatic logic [WIDTH-1:0] neg_if(input logic neg,
                                              input logic [WIDTH-1:0] v);
    return neg ? -v : v;
  endfunction

  assign go        = start && !annul;
  assign last_iter = (cnt == CW'(WIDTH - 1));

  // One restoring step. The difference always lies in (-2^W, 2^W), so the
  // sign bit of the W+1-bit trial gives the compare result directly.
  always_comb begin
    work_shl  = {work, 1'b0};
    trial     = $signed(work_shl[2*WIDTH:WIDTH] - {1'b0, dvs_mag});
    work_step = work_shl[2*WIDTH-1:0];
    if (trial >= 0) begin
      work_step = {trial[WIDTH-1:0], work_shl[WIDTH-1:1], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (go) begin
          state_nxt = (opdata2 == '0) ? ST_BYZERO : ST_ON;
        end
      end
      ST_BYZERO: begin
        state_nxt = annul ? ST_IDLE : ST_END;
      end
      ST_ON: begin
        if (annul) begin
          state_nxt = ST_IDLE;
        end else if (last_iter) begin
          state_nxt = ST_END;
        end
      end
      ST_END: begin
        state_nxt = go ? ST_END : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      dvd_neg <= 1'b0;
      dvs_neg <= 1'b0;
      dvs_mag <= '0;
      work    <= '0;
      result  <= '0;
      ready   <= 1'b0;
    end else begin
      ready <= (state_nxt == ST_END);
      case (state)
        ST_IDLE: begin
          result <= '0;
          if (go && opdata2 != '0) begin
            dvd_neg <= signed_div & opdata1[WIDTH-1];
            dvs_neg <= signed_div & opdata2[WIDTH-1];
            dvs_mag <= neg_if(signed_div & opdata2[WIDTH-1], opdata2);
            work    <= {{WIDTH{1'b0}},
                        neg_if(signed_div & opdata1[WIDTH-1], opdata1)};
            cnt     <= '0;
          end
        end
        ST_BYZERO: begin
          result <= '0;
        end
        ST_ON: begin
          if (!annul) begin
            work <= work_step;
            cnt  <= cnt + CW'(1);
            // Sign fix-up uses the value produced by the final iteration.
            if (last_iter) begin
              result <= {neg_if(dvd_neg, work_step[2*WIDTH-1:WIDTH]),
                         neg_if(dvd_neg ^ dvs_neg, work_step[WIDTH-1:0])};
            end
          end
        end
        ST_END: begin
          if (!go) begin
            result <= '0;
          end
        end
        default: result <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!ready || state == ST_END);
    end
  end

endmodule
